// File: rtl/updown_counter_sched_pkg.sv
// Shared types for the up/down counter scheduler: opcodes, FSM states and the
// default counter width.
package updown_counter_sched_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_UP    = 2'd1,
        OP_DOWN  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_count(input op_t op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/up_down_counter.sv
// Plain up/down counter: synchronous reset, load has priority over counting,
// and it counts on every cycle that load is low (there is no enable).
module up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             updown,
    output logic [WIDTH-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (rst)
            data_out <= '0;
        else if (load)
            data_out <= data;
        else if (updown)
            data_out <= data_out + WIDTH'(1);
        else
            data_out <= data_out - WIDTH'(1);
    end

endmodule

// File: rtl/updown_counter_sched_rr_arb2.sv
// Two-way round-robin grant. The pointer only matters when both requesters are
// valid; the pointer register itself is owned by the parent.
module updown_counter_sched_rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       gnt_id
);

    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (req_valid == 2'b11)
            gnt_id = rr_ptr;
        else
            gnt_id = req_valid[1];
        if (req_valid != 2'b00)
            grant = gnt_id ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/updown_counter_sched.sv
// Shares one enable-less up/down counter between two requesters: arbitrates,
// steers the counter pins for the command's duration and reports the result.
module updown_counter_sched
    import updown_counter_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [WIDTH-1:0] req_arg0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_arg1,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_value,
    output logic             busy,
    output logic             ctr_rst,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_data,
    output logic             ctr_updown,
    input  logic [WIDTH-1:0] ctr_q
);

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] arg_r;
    logic [WIDTH-1:0] remaining;
    logic             owner;
    logic             rr_ptr;
    logic             resp_valid_r;
    logic             busy_r;

    logic [1:0]       grant;
    logic             gnt_id;
    logic             accept;
    op_t              sel_op;
    logic [WIDTH-1:0] sel_arg;

    updown_counter_sched_rr_arb2 u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .gnt_id    (gnt_id)
    );

    assign req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign sel_op    = gnt_id ? op_t'(req_op1) : op_t'(req_op0);
    assign sel_arg   = gnt_id ? req_arg1 : req_arg0;

    // Control state: FSM, arbitration pointer, step counter and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= 1'b0;
            remaining    <= '0;
            owner        <= 1'b0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner     <= gnt_id;
                        rr_ptr    <= ~gnt_id;
                        remaining <= sel_arg;
                        busy_r    <= 1'b1;
                        if (is_count(sel_op) && sel_arg == '0) begin
                            state        <= ST_DONE;
                            resp_valid_r <= 1'b1;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    remaining <= remaining - WIDTH'(1);
                    if (!is_count(op_r) || remaining == WIDTH'(1)) begin
                        state        <= ST_DONE;
                        resp_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Command payload is only meaningful while a command is owned
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r  <= sel_op;
            arg_r <= sel_arg;
        end
    end

    // Counter pins: hold by self-reload unless a command is actively executing
    always_comb begin
        ctr_rst    = rst;
        ctr_load   = 1'b1;
        ctr_data   = ctr_q;
        ctr_updown = 1'b0;
        if (!rst && state == ST_EXEC) begin
            case (op_r)
                OP_LOAD:  ctr_data = arg_r;
                OP_CLEAR: ctr_rst  = 1'b1;
                default: begin
                    ctr_load   = 1'b0;
                    ctr_updown = (op_r == OP_UP);
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = owner;
    assign resp_value = resp_valid_r ? ctr_q : '0;
    assign busy       = busy_r;

endmodule

// File: tb/tb_updown_counter_sched.sv
// Randomised and directed stimulus for the counter scheduler with a queue-based
// scoreboard fed by an arithmetic reference model of the shared counter.
module tb_updown_counter_sched;
    import updown_counter_sched_pkg::*;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [1:0]     req_op0 = 2'd0;
    logic [W-1:0]   req_arg0 = '0;
    logic [1:0]     req_op1 = 2'd0;
    logic [W-1:0]   req_arg1 = '0;
    logic           resp_valid;
    logic           resp_id;
    logic [W-1:0]   resp_value;
    logic           busy;
    logic           ctr_rst;
    logic           ctr_load;
    logic [W-1:0]   ctr_data;
    logic           ctr_updown;
    logic [W-1:0]   ctr_q;

    updown_counter_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_arg0   (req_arg0),
        .req_op1    (req_op1),
        .req_arg1   (req_arg1),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_value (resp_value),
        .busy       (busy),
        .ctr_rst    (ctr_rst),
        .ctr_load   (ctr_load),
        .ctr_data   (ctr_data),
        .ctr_updown (ctr_updown),
        .ctr_q      (ctr_q)
    );

    up_down_counter #(.WIDTH(W)) u_ctr (
        .clk      (clk),
        .rst      (ctr_rst),
        .load     (ctr_load),
        .data     (ctr_data),
        .updown   (ctr_updown),
        .data_out (ctr_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int op; int arg; } cmd_t;
    typedef struct { int id; int val; int due; int up; int dn; int clr; } exp_t;

    cmd_t pend0[$];
    cmd_t pend1[$];
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int mval = 0;
    int mrr = 0;
    int busy_until = -1;
    int last_acc = -1;
    int n_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the counter is just a number mod 2^W; apply the command whole.
    task automatic model_accept(input int id, input int op, input int arg);
        int lat, up, dn, clr;
        up = 0; dn = 0; clr = 0;
        case (op)
            0: begin mval = arg; lat = 2; end
            1: begin mval = (mval + arg) % MOD; up = arg; lat = (arg == 0) ? 1 : arg + 1; end
            2: begin mval = (mval - arg + MOD) % MOD; dn = arg; lat = (arg == 0) ? 1 : arg + 1; end
            default: begin mval = 0; clr = 1; lat = 2; end
        endcase
        sb.push_back('{id, mval, cyc + lat, up, dn, clr});
        last_acc   = cyc;
        busy_until = cyc + lat;
        mrr        = 1 - id;
        n_acc++;
    endtask

    // Driver: presents queued commands, checks the grant, issues expectations
    logic [1:0] exp_rdy;
    bit acc0, acc1;
    initial begin
        forever begin
            @(negedge clk);
            acc0 = 0;
            acc1 = 0;
            if (!rst) begin
                exp_rdy = 2'b00;
                if (cyc > busy_until && req_valid != 2'b00) begin
                    if (req_valid == 2'b11) exp_rdy = (mrr != 0) ? 2'b10 : 2'b01;
                    else                    exp_rdy = req_valid;
                end
                if (req_valid != 2'b00 || req_ready != 2'b00)
                    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (req_ready[0] && req_valid[0]) begin
                    model_accept(0, int'(req_op0), int'(req_arg0));
                    acc0 = 1;
                end
                if (req_ready[1] && req_valid[1]) begin
                    model_accept(1, int'(req_op1), int'(req_arg1));
                    acc1 = 1;
                end
            end
            @(posedge clk);
            #1;
            if (acc0) void'(pend0.pop_front());
            if (acc1) void'(pend1.pop_front());
            req_valid[0] = (pend0.size() > 0);
            req_valid[1] = (pend1.size() > 0);
            if (pend0.size() > 0) begin
                req_op0  = 2'(pend0[0].op);
                req_arg0 = W'(pend0[0].arg);
            end
            if (pend1.size() > 0) begin
                req_op1  = 2'(pend1[0].op);
                req_arg1 = W'(pend1[0].arg);
            end
        end
    end

    // Monitor: pops on every response and checks value, owner, timing and pins
    int   m_up = 0, m_dn = 0, m_clr = 0;
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_up = 0; m_dn = 0; m_clr = 0;
            end else begin
                chk("busy", 32'(busy), 32'(cyc > last_acc && cyc <= busy_until));
                if (ctr_rst) m_clr++;
                if (!ctr_load) begin
                    if (ctr_updown) m_up++;
                    else            m_dn++;
                end
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_resp: got resp id=%0d value=%0d, expected none (cycle %0d)",
                                 resp_id, resp_value, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_cycle", 32'(cyc), 32'(e.due));
                        chk("resp_id", 32'(resp_id), 32'(e.id));
                        chk("resp_value", 32'(resp_value), 32'(e.val));
                        chk("up_steps", 32'(m_up), 32'(e.up));
                        chk("down_steps", 32'(m_dn), 32'(e.dn));
                        chk("clear_pulses", 32'(m_clr), 32'(e.clr));
                    end
                    m_up = 0; m_dn = 0; m_clr = 0;
                end
            end
        end
    end

    task automatic push_cmd(input int id, input int op, input int arg);
        if (id == 0) pend0.push_back('{op, arg});
        else         pend1.push_back('{op, arg});
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d queued, expected 0 within %0d cycles",
                     pend0.size() + pend1.size() + sb.size(), budget);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int a0, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_value", 32'(resp_value), 32'd0);
        chk("rst_ctr_rst", 32'(ctr_rst), 32'd1);
        chk("rst_ctr_q", 32'(ctr_q), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ctr_q", 32'(ctr_q), 32'd0);
        end
        @(posedge clk);
        #2;

        push_cmd(0, 0, 9);  push_cmd(0, 1, 3);                       wait_quiet(100);
        push_cmd(0, 0, 1);  push_cmd(0, 2, 3);                       wait_quiet(100);
        push_cmd(0, 0, 14); push_cmd(0, 1, 5); push_cmd(0, 1, 0);    wait_quiet(100);
        push_cmd(1, 0, 15); push_cmd(1, 1, 1); push_cmd(1, 2, 1);    wait_quiet(100);
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 1, 1);
            push_cmd(1, 2, 1);
        end
        wait_quiet(200);
        push_cmd(1, 0, 7);  push_cmd(1, 3, 0);                       wait_quiet(100);

        // Abort an UP 10 two cycles into execution
        a0 = n_acc;
        push_cmd(0, 1, 10);
        n = 0;
        while (n_acc == a0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("abort_accepted", 32'(n_acc != a0), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        mval = 0; mrr = 0; busy_until = -1; last_acc = -1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_ctr_q", 32'(ctr_q), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        push_cmd(1, 2, 1); push_cmd(0, 1, 2);                        wait_quiet(100);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (pend0.size() == 0 && $urandom_range(0, 3) == 0)
                push_cmd(0, int'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)));
            if (pend1.size() == 0 && $urandom_range(0, 3) == 0)
                push_cmd(1, int'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)));
        end
        wait_quiet(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
